if_fetch_queue: RTL

Parametrised instruction-fetch front end that sits between the sram-like instruction bus and the decode stage. It replaces the single-PC fetch register with three pieces: a fetch-PC generator, a tracker for requests that have been accepted but not yet returned, and a DEPTH-entry {pc, inst} queue. The block keeps up to MAX_OUTSTANDING instruction requests in flight. On a redirect (jump/branch resolved in decode), it flushes the queue and discards stale returns. Decode consumes entries through a valid/ready handshake.

---
 rtl/if_fetch_queue.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction-fetch front end between the sram-like instruction bus and the
// decode stage. It has three parts:
//   - a fetch-PC generator that issues sequential word addresses,
//   - a small FIFO that remembers the PC of every request that the bus has
//     accepted but not yet answered, so each returning word gets its PC back,
//   - a DEPTH-entry {pc, inst} queue that decode drains with valid/ready.
//
// Up to MAX_OUTSTANDING requests may be in flight. A request is issued only
// while the queue is guaranteed to have room for every in-flight response
// (occupancy + outstanding < DEPTH), so the queue never overflows. A redirect
// flushes the queue and marks every response still in flight as stale; stale
// responses are counted down and dropped as they arrive.
//
// Optional feature macro: IF_FETCHQ_BYPASS_EN
//   When defined, a response that arrives while the queue is empty, is not
//   stale, meets out_ready = 1 and does not coincide with a redirect goes
//   straight to out_* in the same cycle and is never written to the queue.
//   When undefined, out_* depend only on registered state.
//
// Parameters:
//   DEPTH           queue entries (power of two, 2..16)
//   MAX_OUTSTANDING maximum accepted-but-unreturned requests (1..DEPTH)
//   RESET_PC        first fetch address after reset
//
// Ports:
//   i_clk            rising-edge clock
//   i_rst            synchronous active-high reset
//   i_redirect       flush and restart fetch at i_redirect_pc
//   i_redirect_pc    new word-aligned fetch address
//   o_inst_req       bus request
//   o_inst_wr        always 0 (fetch only reads)
//   o_inst_size      always 2'b10 (word)
//   o_inst_addr      current fetch PC
//   i_inst_rdata     returned instruction word
//   i_inst_addr_ok   bus accepted the request this cycle
//   i_inst_data_ok   oldest outstanding request returns this cycle
//   o_out_valid      head entry valid for decode
//   i_out_ready      decode accepts the head entry
//   o_out_pc         PC of the head instruction
//   o_out_inst       head instruction word
//   o_occupancy      number of entries currently held in the queue
// ---------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'hBFC0_0000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_redirect,
    input  logic [31:0]              i_redirect_pc,
    output logic                     o_inst_req,
    output logic                     o_inst_wr,
    output logic [1:0]               o_inst_size,
    output logic [31:0]              o_inst_addr,
    input  logic [31:0]              i_inst_rdata,
    input  logic                     i_inst_addr_ok,
    input  logic                     i_inst_data_ok,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [31:0]              o_out_pc,
    output logic [31:0]              o_out_inst,
    output logic [$clog2(DEPTH):0]   o_occupancy
);

    // Queue pointer width, in-flight counter width and tracker pointer width.
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [OW-1:0] MAX_OS   = OW'(MAX_OUTSTANDING);
    localparam logic [AW+1:0] DEPTH_W  = (AW + 2)'(DEPTH);
    localparam logic [TW-1:0] TRK_LAST = TW'(MAX_OUTSTANDING - 1);

    // Fetch PC and in-flight bookkeeping.
    logic [31:0]   r_fetch_pc;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_discard;

    // PC tracker: one entry per accepted request, popped in bus order.
    logic [31:0]   r_trk_pc [MAX_OUTSTANDING];
    logic [TW-1:0] r_trk_rd;
    logic [TW-1:0] r_trk_wr;

    // Instruction queue storage and pointers.
    logic [31:0]   r_q_pc   [DEPTH];
    logic [31:0]   r_q_inst [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;

    logic [AW+1:0] w_inflight;
    logic          w_credit_ok;
    logic          w_req;
    logic          w_accept;
    logic          w_return;
    logic          w_stale;
    logic [31:0]   w_ret_pc;
    logic          w_q_valid;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic [OW-1:0] w_discard_after;

    // Circular increment for the tracker, whose depth need not be a power
    // of two.
    function automatic logic [TW-1:0] trk_next(input logic [TW-1:0] p);
        return (p == TRK_LAST) ? '0 : p + TW'(1);
    endfunction

    // Credit check: only request when the queue can hold every response
    // already in flight plus this one, and the bus window is not full.
    assign w_inflight  = {1'b0, r_count} + (AW + 2)'(r_outstanding);
    assign w_credit_ok = (w_inflight < DEPTH_W) && (r_outstanding < MAX_OS);

    // A redirect cycle never issues: the address about to be presented is
    // already stale, and the new PC is loaded on the coming edge.
    assign w_req    = w_credit_ok && !i_redirect && !i_rst;
    assign w_accept = w_req && i_inst_addr_ok;

    // A data_ok with nothing outstanding is a bus protocol error and is
    // ignored completely so the counters cannot underflow.
    assign w_return  = i_inst_data_ok && (r_outstanding != '0);
    assign w_stale   = w_return && (r_discard != '0);
    assign w_ret_pc  = r_trk_pc[r_trk_rd];
    assign w_q_valid = (r_count != '0);

    // Responses that survive a redirect in the same cycle would belong to
    // the old path, so they are all counted as stale from then on.
    assign w_discard_after = r_outstanding - OW'(w_return);

`ifdef IF_FETCHQ_BYPASS_EN
    // Empty queue and a live response that decode takes right now: hand it
    // over directly instead of spending a cycle in the queue.
    assign w_bypass = !w_q_valid && w_return && !w_stale && i_out_ready
                      && !i_redirect && !i_rst;

    assign o_out_valid = w_q_valid || w_bypass;
    assign o_out_pc    = w_bypass  ? w_ret_pc
                       : (w_q_valid ? r_q_pc[r_rd_ptr]   : 32'h0);
    assign o_out_inst  = w_bypass  ? i_inst_rdata
                       : (w_q_valid ? r_q_inst[r_rd_ptr] : 32'h0);
`else
    assign w_bypass = 1'b0;

    // Outputs come purely from registers; an empty queue shows zeros so the
    // head fields read as 0 after reset rather than stale storage.
    assign o_out_valid = w_q_valid;
    assign o_out_pc    = w_q_valid ? r_q_pc[r_rd_ptr]   : 32'h0;
    assign o_out_inst  = w_q_valid ? r_q_inst[r_rd_ptr] : 32'h0;
`endif

    assign w_push = w_return && !w_stale && !i_redirect && !w_bypass;
    assign w_pop  = w_q_valid && i_out_ready;

    assign o_inst_req  = w_req;
    assign o_inst_wr   = 1'b0;
    assign o_inst_size = 2'b10;
    assign o_inst_addr = r_fetch_pc;
    assign o_occupancy = r_count;

    // Control state: fetch PC, in-flight/discard counters, tracker and queue
    // pointers. The tracker keeps moving during a redirect because stale
    // responses still need to be matched up and retired in order; only the
    // queue and the fetch PC are restarted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_trk_rd      <= '0;
            r_trk_wr      <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else begin
            if (w_accept) begin
                r_trk_wr <= trk_next(r_trk_wr);
            end
            if (w_return) begin
                r_trk_rd <= trk_next(r_trk_rd);
            end
            r_outstanding <= r_outstanding + OW'(w_accept) - OW'(w_return);

            if (i_redirect) begin
                r_fetch_pc <= i_redirect_pc;
                r_discard  <= w_discard_after;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_stale) begin
                    r_discard <= r_discard - OW'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_count <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
            end
        end
    end

    // Storage arrays carry no reset: every entry is written before the
    // pointers can make it visible, so clearing them would buy nothing.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_trk_pc[r_trk_wr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_q_pc[r_wr_ptr]   <= w_ret_pc;
            r_q_inst[r_wr_ptr] <= i_inst_rdata;
        end
    end

endmodule
